// File: rtl/io_pkg.sv
// Port map and status-bit layout shared by the CPU port-I/O responder.
package io_pkg;

    localparam int unsigned IO_AW = 16;
    localparam int unsigned IO_DW = 16;
    localparam int unsigned SCRATCH_N = 8;

    localparam logic [IO_AW-1:0] IO_CON_TX       = 16'h0000;
    localparam logic [IO_AW-1:0] IO_CON_STAT     = 16'h0001;
    localparam logic [IO_AW-1:0] IO_TIMER        = 16'h0002;
    localparam logic [IO_AW-1:0] IO_TIMER_CTRL   = 16'h0003;
    localparam logic [IO_AW-1:0] IO_SCRATCH_BASE = 16'h0010;

    // CON_STAT bit positions
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;

    // Scratch block occupies the 8-aligned window at IO_SCRATCH_BASE
    function automatic logic is_scratch(input logic [IO_AW-1:0] a);
        return a[IO_AW-1:3] == IO_SCRATCH_BASE[IO_AW-1:3];
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Console TX byte FIFO.
// Ports: clk, sync_rst (sync, active-high), push/push_data in, pop in,
// full/empty/head out (combinational from registered state).
// A push while full is accepted only when a pop frees the head slot at the same edge.
module io_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       sync_rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push_c;
    logic          do_pop_c;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head byte reads zero afterwards
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// CPU port-I/O responder: console TX FIFO, prescaled timer, scratch registers.
// Ports: clk, sync_rst (sync, active-high); addr/data/write level-held from CPU;
// data_out registered read data (1-cycle latency); tx_valid/tx_byte/tx_ready
// valid/ready console sink.
module io_port_bank
    import io_pkg::*;
#(
    parameter int unsigned TX_DEPTH       = 8,
    parameter int unsigned TIMER_PRESCALE = 4
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic [IO_AW-1:0] addr,
    input  logic [IO_DW-1:0] data,
    input  logic             write,
    output logic [IO_DW-1:0] data_out,
    output logic             tx_valid,
    output logic [7:0]       tx_byte,
    input  logic             tx_ready
);

    localparam int unsigned PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TIMER_PRESCALE - 1);

    logic             last_write;
    logic [IO_AW-1:0] last_addr;
    logic [IO_DW-1:0] last_data;
    logic             overflow;
    logic             tmr_en;
    logic [IO_DW-1:0] timer;
    logic [PW-1:0]    pre_cnt;
    logic [IO_DW-1:0] scratch [SCRATCH_N];

    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_evt_c;
    logic             wr_con_tx_c;
    logic             wr_stat_c;
    logic             wr_timer_c;
    logic             wr_ctrl_c;
    logic             pop_c;
    logic [IO_DW-1:0] rd_mux_c;

    // A held write level with unchanged addr/data is one event, not one per cycle
    assign wr_evt_c    = write && (!last_write || addr != last_addr || data != last_data);
    assign wr_con_tx_c = wr_evt_c && (addr == IO_CON_TX);
    assign wr_stat_c   = wr_evt_c && (addr == IO_CON_STAT);
    assign wr_timer_c  = wr_evt_c && (addr == IO_TIMER);
    assign wr_ctrl_c   = wr_evt_c && (addr == IO_TIMER_CTRL);

    assign tx_valid = !fifo_empty;
    assign pop_c    = tx_valid && tx_ready;

    io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .push      (wr_con_tx_c),
        .push_data (data[7:0]),
        .pop       (pop_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (tx_byte)
    );

    // Read mux, registered into data_out below
    always_comb begin
        rd_mux_c = '0;
        if (is_scratch(addr)) begin
            rd_mux_c = scratch[addr[2:0]];
        end else begin
            case (addr)
                IO_CON_STAT: begin
                    rd_mux_c[STAT_EMPTY_BIT] = fifo_empty;
                    rd_mux_c[STAT_FULL_BIT]  = fifo_full;
                    rd_mux_c[STAT_OVF_BIT]   = overflow;
                end
                IO_TIMER:      rd_mux_c = timer;
                IO_TIMER_CTRL: rd_mux_c[0] = tmr_en;
                default:       rd_mux_c = '0;
            endcase
        end
    end

    // Input history, status, timer enable and read data
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            last_write <= 1'b0;
            last_addr  <= '0;
            last_data  <= '0;
            overflow   <= 1'b0;
            tmr_en     <= 1'b1;
            data_out   <= '0;
        end else begin
            last_write <= write;
            last_addr  <= addr;
            last_data  <= data;
            data_out   <= rd_mux_c;
            if (wr_stat_c)
                overflow <= 1'b0;
            else if (wr_con_tx_c && fifo_full && !pop_c)
                overflow <= 1'b1;
            if (wr_ctrl_c) tmr_en <= data[0];
        end
    end

    // Prescaled timer; a CPU load wins over an increment
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            timer   <= '0;
            pre_cnt <= '0;
        end else if (wr_timer_c) begin
            timer   <= data;
            pre_cnt <= '0;
        end else if (tmr_en) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                timer   <= timer + IO_DW'(1);
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    // Scratch registers
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int unsigned i = 0; i < SCRATCH_N; i++) scratch[i] <= '0;
        end else if (wr_evt_c && is_scratch(addr)) begin
            scratch[addr[2:0]] <= data;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
module tb_io_port_bank;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic [15:0] addr;
    logic [15:0] data;
    logic        write;
    logic        tx_ready;
    logic [15:0] data_out;
    logic        tx_valid;
    logic [7:0]  tx_byte;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        w;
        logic        r;
        logic [15:0] exp_do;
        logic        exp_v;
        logic [7:0]  exp_b;
    } vec_t;

    vec_t vecs[$];

    io_port_bank #(.TX_DEPTH(8), .TIMER_PRESCALE(4)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .addr     (addr),
        .data     (data),
        .write    (write),
        .data_out (data_out),
        .tx_valid (tx_valid),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        addr = a; data = d; write = w; tx_ready = r;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r,
                       input logic [15:0] eo, input logic ev, input logic [7:0] eb);
        vec_t v;
        v.a = a; v.d = d; v.w = w; v.r = r; v.exp_do = eo; v.exp_v = ev; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].r);
            tick();
            chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_do));
            chk($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v)
                chk($sformatf("vec%0d tx_byte", i), 32'(tx_byte), 32'(vecs[i].exp_b));
        end
    endtask

    task automatic drain_expect(input string name, input logic [7:0] first, input int n);
        drive(16'h0020, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s valid%0d", name, i), 32'(tx_valid), 32'd1);
            chk($sformatf("%s byte%0d", name, i), 32'(tx_byte), 32'(first + 8'(i)));
            tick();
        end
        chk($sformatf("%s empty", name), 32'(tx_valid), 32'd0);
    endtask

    initial begin
        // Section A (0..6): three console bytes with a read between each
        add(16'h0000, 16'h0041, 1, 1, 16'h0000, 1, 8'h41);
        add(16'h0000, 16'h0041, 0, 1, 16'h0000, 0, 8'h00);
        add(16'h0000, 16'h0042, 1, 1, 16'h0000, 1, 8'h42);
        add(16'h0000, 16'h0042, 0, 1, 16'h0000, 0, 8'h00);
        add(16'h0000, 16'h0043, 1, 1, 16'h0000, 1, 8'h43);
        add(16'h0001, 16'h0043, 0, 1, 16'h0000, 0, 8'h00);
        add(16'h0001, 16'h0000, 0, 1, 16'h0001, 0, 8'h00);
        // Section B (7..17): scratch, same-cycle write/read, unmapped and aliases
        add(16'h0013, 16'hBEEF, 1, 0, 16'h0000, 0, 8'h00);
        add(16'h0013, 16'hBEEF, 0, 0, 16'hBEEF, 0, 8'h00);
        add(16'h0010, 16'h1234, 1, 0, 16'h0000, 0, 8'h00);
        add(16'h0017, 16'h0000, 0, 0, 16'h0000, 0, 8'h00);
        add(16'h0010, 16'h0000, 0, 0, 16'h1234, 0, 8'h00);
        add(16'h0018, 16'hDEAD, 1, 0, 16'h0000, 0, 8'h00);
        add(16'h0018, 16'h0000, 0, 0, 16'h0000, 0, 8'h00);
        add(16'h0113, 16'h0000, 0, 0, 16'h0000, 0, 8'h00);
        add(16'h0013, 16'h0000, 0, 0, 16'hBEEF, 0, 8'h00);
        add(16'h0013, 16'h5555, 1, 0, 16'hBEEF, 0, 8'h00);
        add(16'h0013, 16'h0000, 0, 0, 16'h5555, 0, 8'h00);

        // Reset and idle
        sync_rst = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        tick(); tick();
        chk("rst data_out", 32'(data_out), 32'd0);
        chk("rst tx_valid", 32'(tx_valid), 32'd0);
        chk("rst tx_byte", 32'(tx_byte), 32'd0);
        sync_rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle data_out", 32'(data_out), 32'd0);
        chk("idle tx_valid", 32'(tx_valid), 32'd0);
        drive(16'h0002, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("idle timer", 32'(data_out), 32'd2);

        run_vecs(0, 6);

        // Overflow: nine distinct pushes into an 8-deep FIFO with the sink stalled
        for (int i = 0; i < 9; i++) begin
            drive(16'h0000, 16'h0050 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        drive(16'h0001, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("ovf stat", 32'(data_out), 32'h6);
        drive(16'h0001, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("ovf clear old", 32'(data_out), 32'h6);
        drive(16'h0001, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("ovf cleared", 32'(data_out), 32'h2);
        drain_expect("ovf drain", 8'h50, 8);

        // Full FIFO: push and pop on the same edge
        for (int i = 0; i < 8; i++) begin
            drive(16'h0000, 16'h0060 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        chk("full head", 32'(tx_byte), 32'h60);
        drive(16'h0000, 16'h0068, 1'b1, 1'b1);
        tick();
        chk("pushpop head", 32'(tx_byte), 32'h61);
        drive(16'h0001, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("pushpop stat", 32'(data_out), 32'h2);
        drain_expect("pushpop drain", 8'h61, 8);

        // Held write level: one event until data changes
        begin
            logic [7:0] got[$];
            for (int i = 0; i < 5; i++) begin
                drive(16'h0000, 16'h0070, 1'b1, 1'b0);
                tick();
            end
            drive(16'h0000, 16'h0071, 1'b1, 1'b0);
            tick();
            drive(16'h0020, 16'h0000, 1'b0, 1'b1);
            for (int c = 0; c < 6; c++) begin
                if (tx_valid) got.push_back(tx_byte);
                tick();
            end
            chk("held count", 32'(got.size()), 32'd2);
            if (got.size() >= 2) begin
                chk("held byte0", 32'(got[0]), 32'h70);
                chk("held byte1", 32'(got[1]), 32'h71);
            end
        end

        run_vecs(7, 17);

        // Timer load and wrap
        drive(16'h0002, 16'hFFFE, 1'b1, 1'b0);
        tick();
        drive(16'h0002, 16'h0000, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 4) chk("tmr k4", 32'(data_out), 32'hFFFE);
            if (k == 5) chk("tmr k5", 32'(data_out), 32'hFFFF);
            if (k == 8) chk("tmr k8", 32'(data_out), 32'hFFFF);
            if (k == 9) chk("tmr k9", 32'(data_out), 32'h0000);
        end

        // Disable freezes timer and prescaler; re-enable resumes mid-prescale
        drive(16'h0003, 16'h0000, 1'b1, 1'b0);
        tick();
        drive(16'h0003, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("ctrl off", 32'(data_out), 32'd0);
        drive(16'h0002, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("tmr frozen", 32'(data_out), 32'd0);
        drive(16'h0003, 16'h0001, 1'b1, 1'b0);
        tick();
        drive(16'h0002, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        chk("tmr resume0", 32'(data_out), 32'd0);
        tick();
        chk("tmr resume1", 32'(data_out), 32'd1);

        // Reset while draining
        for (int i = 0; i < 3; i++) begin
            drive(16'h0000, 16'h0080 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        drive(16'h0020, 16'h0000, 1'b0, 1'b1);
        tick();
        chk("mid valid", 32'(tx_valid), 32'd1);
        chk("mid byte", 32'(tx_byte), 32'h81);
        sync_rst = 1'b1;
        tick();
        chk("midrst valid", 32'(tx_valid), 32'd0);
        chk("midrst byte", 32'(tx_byte), 32'd0);
        chk("midrst data_out", 32'(data_out), 32'd0);
        sync_rst = 1'b0;
        drive(16'h0003, 16'h0000, 1'b0, 1'b1);
        tick();
        chk("post ctrl", 32'(data_out), 32'd1);
        drive(16'h0013, 16'h0000, 1'b0, 1'b1);
        tick();
        chk("post scratch", 32'(data_out), 32'd0);
        chk("post valid", 32'(tx_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Responder side of the CPU port-I/O interface: services `pst` writes and `pld` reads.
- Contains three port-mapped resources:
  - console TX byte FIFO, drained over a valid/ready sink interface;
  - free-running prescaled timer;
  - eight scratch registers.
- Sits beside the CPU on the same clock.
- Consumes the CPU's level-held addr/data/write signals and returns registered read data.

Parameters:
- TX_DEPTH, 8, console FIFO entries; power of two, 2..256.
- TIMER_PRESCALE, 4, clock cycles per timer increment; at least 1.

Ports:
- clk  in  1  system clock; single clock domain.
- sync_rst  in  1  reset; synchronous, active-high.
- addr  in  16  port address from CPU; held until the CPU changes it.
- data  in  16  write data from CPU; held.
- write  in  1  write level from CPU; stays high after a `pst` until the next `pld`.
- data_out  out  16  registered read data for the address sampled on the previous edge.
- tx_valid  out  1  FIFO head byte available.
- tx_byte  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts tx_byte when tx_valid && tx_ready at the edge.

Behaviour:
- Reset (sync_rst high at an edge, overrides everything in that cycle):
  - data_out=0, tx_valid=0, tx_byte=0;
  - FIFO empty, overflow=0;
  - timer=0, prescale counter=0, timer enable=1;
  - scratch=0;
  - last-sample registers: write=0, addr=0, data=0.
- Write event:
  - Defined as write=1 AND (last_write=0 OR addr!=last_addr OR data!=last_data).
  - last_* are registered copies of the inputs, updated every cycle.
  - Because write is level-held, consecutive identical `pst` (same addr and data) with write still high produce ONE event. This is decided behaviour; software interleaves a `pld` to re-arm.
  - A write event commits at that edge.
- Port map (addr exact match):
  - 0x0000 CON_TX
    - Write: push data[7:0].
    - If full and no pop in the same cycle: drop the byte, set overflow (sticky).
    - Read: 0.
  - 0x0001 CON_STAT
    - Read: {13'b0, overflow, full, empty}.
    - Write: any value clears overflow.
  - 0x0002 TIMER
    - Read: timer count.
    - Write: load timer=data and reset prescale counter to 0.
  - 0x0003 TIMER_CTRL
    - Read: {15'b0, enable}.
    - Write: enable=data[0].
  - 0x0010..0x0017 SCRATCH[addr[2:0]]
    - Read/write 16-bit.
  - All other addresses: read 0, writes ignored.
- Read path:
  - data_out <= mux(addr) every edge, regardless of write. Latency is 1 cycle.
  - Same-cycle write+read of one location: data_out shows the OLD value; the new value appears one cycle later.
  - Reads have no side effects.
- Timer:
  - While enable=1, the prescale counter counts 0..TIMER_PRESCALE-1.
  - On terminal count, timer increments, wrapping 0xFFFF->0x0000.
  - enable=0 freezes both the timer and the prescale counter.
  - A TIMER write takes priority over an increment in the same cycle.
- FIFO:
  - Pointers are log2(TX_DEPTH) bits with wrap.
  - Occupancy counter runs 0..TX_DEPTH.
  - tx_valid = !empty; tx_byte = mem[rd_ptr] (combinational from registered state).
  - Pop when tx_valid && tx_ready.
  - Push to an empty FIFO: tx_valid rises the next cycle; no fall-through.
  - Push and pop in the same cycle: both succeed, occupancy unchanged. This holds even when full, and the push does not overflow.
  - Pop on empty cannot occur (tx_valid=0).
- Reset mid-operation: FIFO contents are discarded, tx_valid drops the same edge, and a pending write event is lost.
- No combinational path from any input to any output. The only combinational outputs are tx_valid/tx_byte, driven from FIFO state.

Decomposition:
- Package io_pkg:
  - port address constants: IO_CON_TX, IO_CON_STAT, IO_TIMER, IO_TIMER_CTRL, IO_SCRATCH_BASE;
  - CON_STAT bit indices.
- Sub-module io_tx_fifo:
  - parameter DEPTH;
  - ports: clk, sync_rst, push, push_data[7:0], pop, full, empty, head[7:0].
  - Overflow flag stays in io_port_bank.

Test Plan:
- Reset then idle 10 cycles:
  - data_out=0, tx_valid=0;
  - after addr=0x0002, data_out reads 2 (timer at 10 cycles / PRESCALE 4).
- Write 0x41, 0x42, 0x43 to 0x0000, with a `pld` between each, tx_ready=1:
  - tx_byte sequence 0x41, 0x42, 0x43, each with tx_valid one cycle after its push;
  - CON_STAT then reads 0x0001.
- tx_ready=0, nine distinct writes to CON_TX:
  - first 8 stored;
  - CON_STAT reads 0x0006 (overflow+full);
  - write 0 to CON_STAT -> 0x0002;
  - drain yields exactly the first 8 bytes.
- Full FIFO, tx_ready=1 on the same edge as a push:
  - occupancy stays 8;
  - overflow stays 0;
  - the pushed byte is last out.
- Write held high with identical addr/data for 5 cycles:
  - exactly one FIFO push;
  - changing data to a new value while still high -> second push.
- SCRATCH[3]=0xBEEF, TIMER load 0xFFFE with enable=1, PRESCALE 4:
  - SCRATCH[3] reads 0xBEEF;
  - timer reads 0xFFFF after 4 cycles and 0x0000 after 8;
  - assert sync_rst mid-drain -> tx_valid=0 on that edge.
